muldiv_sequencer: RTL

- Multi-cycle unsigned multiply/divide unit for the EX stage. Runs shift-add multiplication and restoring division, one add/sub step per clock.
- Uses a private add/sub datapath driven with the shared ALU_add/ALU_sub control codes.
- Asserts stall to the pipeline control while an operation is in flight.
- Returns a 2×WIDTH result split as hi/lo (hi = remainder, lo = quotient for divide).

---
 rtl/muldiv_sequencer_pkg.sv | 24 ++
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_addsub.sv | 23 ++
 rtl/muldiv_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: ALU control
// codes used by the private add/sub datapath, operation select codes and the
// sequencer state encoding.
package muldiv_sequencer_pkg;

  localparam int unsigned ALU_CTRL_W = 5;

  // ALU control codes shared with the main EX-stage ALU
  localparam logic [ALU_CTRL_W-1:0] ALU_add = 5'b00000;
  localparam logic [ALU_CTRL_W-1:0] ALU_sub = 5'b00001;

  // Operation select
  localparam logic MD_OP_MULU = 1'b0;
  localparam logic MD_OP_DIVU = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX-stage pipeline control and the
// multiply/divide unit.
//   master: pipeline side (drives start/op/operands/abort)
//   slave : muldiv unit (drives busy/stall/done/results/div_by_zero)
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             abort;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, abort,
    input  busy, stall, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, abort,
    output busy, stall, done, result_hi, result_lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_addsub.sv
// Combinational W-bit adder/subtractor selected by an ALU control code.
//   alu_ctrl_i : ALU_sub selects a_i - b_i, any other code selects a_i + b_i
//   a_i, b_i   : operands
//   res_c_o    : result (combinational)
module muldiv_addsub
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned W = 33
) (
  input  logic [ALU_CTRL_W-1:0] alu_ctrl_i,
  input  logic [W-1:0]          a_i,
  input  logic [W-1:0]          b_i,
  output logic [W-1:0]          res_c_o
);

  always_comb begin
    res_c_o = a_i + b_i;
    if (alu_ctrl_i == ALU_sub) begin
      res_c_o = a_i - b_i;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit for the
// EX stage, one add/sub step per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   md         : slave side of muldiv_sequencer_if (start/op/operands/abort in;
//                busy/stall/done/result_hi/result_lo/div_by_zero out).
//                stall is combinational, all other outputs are registered.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave md
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  md_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       acc_q, acc_d;       // product high / remainder
  logic [WIDTH-1:0]       wlo_q, wlo_d;       // multiplier / quotient
  logic [WIDTH-1:0]       opb_q, opb_d;       // multiplicand / divisor
  logic [WIDTH-1:0]       res_hi_q, res_hi_d;
  logic [WIDTH-1:0]       res_lo_q, res_lo_d;
  logic                   dbz_q, dbz_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [ALU_CTRL_W-1:0]  alu_ctrl;
  logic [WIDTH:0]         alu_a;
  logic [WIDTH:0]         alu_b;
  logic [WIDTH:0]         alu_res;
  logic [WIDTH:0]         mul_sum;

  muldiv_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .alu_ctrl_i (alu_ctrl),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .res_c_o    (alu_res)
  );

  // Next-state, datapath step and output staging
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wlo_d    = wlo_q;
    opb_d    = opb_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;
    alu_ctrl = ALU_add;
    alu_a    = {1'b0, acc_q};
    alu_b    = {1'b0, opb_q};
    mul_sum  = {1'b0, acc_q};

    case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (md.start && !md.abort) begin
          cnt_d = CNT_W'(WIDTH);
          acc_d = '0;
          wlo_d = md.operand_a;
          opb_d = md.operand_b;
          dbz_d = 1'b0;
          if (md.op == MD_OP_MULU) begin
            state_d = MD_MUL;
          end else if (md.operand_b != '0) begin
            state_d = MD_DIV;
          end else begin
            // Divide by zero completes immediately with a fixed result
            state_d  = MD_DONE;
            res_hi_d = md.operand_a;
            res_lo_d = '1;
            dbz_d    = 1'b1;
          end
        end
      end

      MD_MUL: begin
        alu_ctrl = ALU_add;
        if (wlo_q[0]) begin
          mul_sum = alu_res;
        end
        // Carry of the partial sum shifts into the accumulator MSB
        acc_d = mul_sum[WIDTH:1];
        wlo_d = {mul_sum[0], wlo_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (md.abort) begin
          state_d = MD_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = MD_DONE;
          res_hi_d = acc_d;
          res_lo_d = wlo_d;
        end
      end

      MD_DIV: begin
        alu_ctrl = ALU_sub;
        // The remainder bit shifted out on the left must take part in the
        // trial compare, otherwise divisors above 2^(WIDTH-1) fail.
        alu_a = {acc_q, wlo_q[WIDTH-1]};
        if (!alu_res[WIDTH]) begin
          acc_d = alu_res[WIDTH-1:0];
          wlo_d = {wlo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], wlo_q[WIDTH-1]};
          wlo_d = {wlo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (md.abort) begin
          state_d = MD_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = MD_DONE;
          res_hi_d = acc_d;
          res_lo_d = wlo_d;
        end
      end

      default: state_d = MD_IDLE;
    endcase

    busy_d = (state_d == MD_MUL) || (state_d == MD_DIV);
    done_d = (state_d == MD_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      wlo_q    <= '0;
      opb_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wlo_q    <= wlo_d;
      opb_q    <= opb_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign md.busy        = busy_q;
  assign md.done        = done_q;
  assign md.result_hi   = res_hi_q;
  assign md.result_lo   = res_lo_q;
  assign md.div_by_zero = dbz_q;
  // Hold the pipeline in the cycle a start is being accepted as well
  assign md.stall = busy_q |
                    (md.start & ~md.abort &
                     ((state_q == MD_IDLE) | (state_q == MD_DONE)));

endmodule
